// File: rtl/uart_cmd_ctrl.sv
// ============================================================================
// Module   : uart_cmd_ctrl
// Purpose  : Command-frame controller behind the UART receiver. Parses
//            5-byte frames (HDR, CMD, ADDR, DATA, CHK), runs one register-bus
//            read or write per frame and queues a 1- or 2-byte response
//            toward the UART transmitter.
// Ports    : clk, rst_n           - clock, asynchronous active-low reset
//            rx_data/rx_valid     - received byte stream (1-cycle strobes)
//            reg_addr/reg_wdata   - register bus address / write data
//            reg_wr_en/reg_rd_en  - bus requests, held until ack or timeout
//            reg_rdata/reg_ack    - bus read data / 1-cycle completion
//            tx_data/tx_valid     - response byte toward the transmitter
//            tx_ready             - transmitter accepts on valid && ready
//            frame_err            - 1-cycle pulse on inter-byte timeout
//            overrun              - 1-cycle pulse when a byte is dropped
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_ctrl #(
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter int          BUS_TIMEOUT    = 255,
  parameter logic [7:0]  HDR_BYTE       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rdata,
  input  logic       reg_ack,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int IB_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BUS_W = (BUS_TIMEOUT > 1)    ? $clog2(BUS_TIMEOUT)    : 1;
  localparam logic [IB_W-1:0]  IB_LAST  = IB_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BUS_W-1:0] BUS_LAST = BUS_W'(BUS_TIMEOUT - 1);

  localparam logic [7:0] CMD_WR      = 8'h01;
  localparam logic [7:0] CMD_RD      = 8'h02;
  localparam logic [7:0] RSP_OK      = 8'h5A;
  localparam logic [7:0] RSP_BAD_CHK = 8'hEE;
  localparam logic [7:0] RSP_BAD_CMD = 8'hEF;
  localparam logic [7:0] RSP_BUS_TO  = 8'hED;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_GET_CMD  = 3'd1;
  localparam logic [2:0] S_GET_ADDR = 3'd2;
  localparam logic [2:0] S_GET_DATA = 3'd3;
  localparam logic [2:0] S_GET_CHK  = 3'd4;
  localparam logic [2:0] S_BUS      = 3'd5;
  localparam logic [2:0] S_RESP0    = 3'd6;
  localparam logic [2:0] S_RESP1    = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       chk_q, chk_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [7:0]       resp_q, resp_d;
  logic [IB_W-1:0]  ib_cnt_q, ib_cnt_d;
  logic [BUS_W-1:0] bus_cnt_q, bus_cnt_d;

  logic             reg_wr_en_q, reg_wr_en_d;
  logic             reg_rd_en_q, reg_rd_en_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic             abort;
  logic             drop;
  logic             tx_hs;
  logic [7:0]       chk_calc;

  assign tx_hs    = tx_valid_q && tx_ready;
  assign chk_calc = cmd_q ^ addr_q ^ data_q;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      chk_q       <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
      ib_cnt_q    <= '0;
      bus_cnt_q   <= '0;
      reg_wr_en_q <= 1'b0;
      reg_rd_en_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      chk_q       <= chk_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      ib_cnt_q    <= ib_cnt_d;
      bus_cnt_q   <= bus_cnt_d;
      reg_wr_en_q <= reg_wr_en_d;
      reg_rd_en_q <= reg_rd_en_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    chk_d     = chk_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    ib_cnt_d  = ib_cnt_q;
    bus_cnt_d = bus_cnt_q;
    abort     = 1'b0;
    drop      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Non-header bytes are discarded without any indication.
        if (rx_valid && (rx_data == HDR_BYTE)) begin
          state_d  = S_GET_CMD;
          ib_cnt_d = '0;
        end
      end

      S_GET_CMD, S_GET_ADDR, S_GET_DATA, S_GET_CHK: begin
        // An arriving byte always wins over the timeout in the same cycle.
        if (rx_valid) begin
          ib_cnt_d = '0;
          if (state_q == S_GET_CMD) begin
            cmd_d   = rx_data;
            state_d = S_GET_ADDR;
          end else if (state_q == S_GET_ADDR) begin
            addr_d  = rx_data;
            state_d = S_GET_DATA;
          end else if (state_q == S_GET_DATA) begin
            data_d  = rx_data;
            state_d = S_GET_CHK;
          end else begin
            chk_d = rx_data;
            // Checksum takes priority over command decoding.
            if (rx_data != chk_calc) begin
              resp_d  = RSP_BAD_CHK;
              state_d = S_RESP0;
            end else if ((cmd_q != CMD_WR) && (cmd_q != CMD_RD)) begin
              resp_d  = RSP_BAD_CMD;
              state_d = S_RESP0;
            end else begin
              bus_cnt_d = '0;
              state_d   = S_BUS;
            end
          end
        end else if (ib_cnt_q == IB_LAST) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else begin
          ib_cnt_d = ib_cnt_q + IB_W'(1);
        end
      end

      S_BUS: begin
        drop = rx_valid;
        if (reg_ack) begin
          resp_d  = RSP_OK;
          state_d = S_RESP0;
          if (cmd_q == CMD_RD) begin
            rdata_d = reg_rdata;
          end
        end else if (bus_cnt_q == BUS_LAST) begin
          resp_d  = RSP_BUS_TO;
          state_d = S_RESP0;
        end else begin
          bus_cnt_d = bus_cnt_q + BUS_W'(1);
        end
      end

      S_RESP0: begin
        drop = rx_valid;
        if (tx_hs) begin
          // Only a successful read carries a second (data) byte.
          if ((resp_q == RSP_OK) && (cmd_q == CMD_RD)) begin
            state_d = S_RESP1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_RESP1: begin
        drop = rx_valid;
        if (tx_hs) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: outputs are registered from the upcoming state, so the bus
  // enables and tx_valid appear the cycle after the deciding event and a
  // RESP1 byte can follow the RESP0 handshake with no idle cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    reg_wr_en_d = (state_d == S_BUS) && (cmd_d == CMD_WR);
    reg_rd_en_d = (state_d == S_BUS) && (cmd_d == CMD_RD);
    tx_valid_d  = (state_d == S_RESP0) || (state_d == S_RESP1);
    if (state_d == S_RESP0) begin
      tx_data_d = resp_d;
    end else if (state_d == S_RESP1) begin
      tx_data_d = rdata_d;
    end else begin
      tx_data_d = '0;
    end
    frame_err_d = abort;
    overrun_d   = drop;
  end

  assign reg_addr  = addr_q;
  assign reg_wdata = data_q;
  assign reg_wr_en = reg_wr_en_q;
  assign reg_rd_en = reg_rd_en_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
// ============================================================================
// Module   : tb_uart_cmd_ctrl
// Purpose  : Self-checking bench for uart_cmd_ctrl. A table of complete
//            frames with hand-computed responses, plus directed sequences for
//            backpressure, inter-byte timeout, bus timeout/overrun and reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_ctrl;

  localparam int TO_CYC = 20;
  localparam int BUS_TO = 10;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rdata;
  logic       reg_ack;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       frame_err;
  logic       overrun;

  uart_cmd_ctrl #(
    .TIMEOUT_CYCLES(TO_CYC),
    .BUS_TIMEOUT   (BUS_TO),
    .HDR_BYTE      (8'hA5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wr_en(reg_wr_en),
    .reg_rd_en(reg_rd_en),
    .reg_rdata(reg_rdata),
    .reg_ack  (reg_ack),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed activity, sampled on the falling edge.
  logic [7:0] tx_q[$];
  int wr_cyc = 0;
  int rd_cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  always @(negedge clk) begin
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (reg_wr_en) wr_cyc++;
    if (reg_rd_en) rd_cyc++;
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
  end

  typedef struct {
    logic [39:0] frame;   // HDR, CMD, ADDR, DATA, CHK from MSB down
    bit          ack;
    logic [7:0]  rdata;
    bit          exp_wr;
    bit          exp_rd;
    int          ntx;
    logic [7:0]  tx0;
    logic [7:0]  tx1;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte is sampled on the second rising edge; returns 1 time unit after it.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int k = 0; k < 5; k++) begin
      logic [39:0] tmp;
      tmp = f;
      send_byte(tmp[8*(4-k) +: 8]);
    end
  endtask

  // Ack three cycles after the enable is seen; returns in the cycle after ack.
  task automatic do_ack(input logic [7:0] rd);
    repeat (2) @(posedge clk);
    #1;
    reg_ack   = 1'b1;
    reg_rdata = rd;
    @(posedge clk); #1;
    reg_ack   = 1'b0;
    reg_rdata = 8'h00;
  endtask

  initial begin
    int n0;
    int w0;
    int r0;
    int f0;
    int o0;

    vecs[0] = '{40'hA5_01_10_3C_2D, 1'b1, 8'h00, 1'b1, 1'b0, 1, 8'h5A, 8'h00};
    vecs[1] = '{40'hA5_02_20_00_22, 1'b1, 8'hC3, 1'b0, 1'b1, 2, 8'h5A, 8'hC3};
    vecs[2] = '{40'hA5_01_10_3C_00, 1'b0, 8'h00, 1'b0, 1'b0, 1, 8'hEE, 8'h00};
    vecs[3] = '{40'hA5_07_00_00_07, 1'b0, 8'h00, 1'b0, 1'b0, 1, 8'hEF, 8'h00};
    vecs[4] = '{40'hA5_02_55_AA_FD, 1'b1, 8'h00, 1'b0, 1'b1, 2, 8'h5A, 8'h00};
    vecs[5] = '{40'hA5_01_FF_81_7F, 1'b1, 8'h00, 1'b1, 1'b0, 1, 8'h5A, 8'h00};
    vecs[6] = '{40'hA5_03_00_00_03, 1'b0, 8'h00, 1'b0, 1'b0, 1, 8'hEF, 8'h00};
    vecs[7] = '{40'hA5_07_00_00_00, 1'b0, 8'h00, 1'b0, 1'b0, 1, 8'hEE, 8'h00};
    vecs[8] = '{40'hA5_00_00_00_00, 1'b0, 8'h00, 1'b0, 1'b0, 1, 8'hEF, 8'h00};

    rst_n     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    reg_rdata = 8'h00;
    reg_ack   = 1'b0;
    tx_ready  = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", {31'd0, reg_wr_en}, 0);
    chk("rst_rd_en", {31'd0, reg_rd_en}, 0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 0);
    chk("rst_tx_data", {24'd0, tx_data}, 0);
    chk("rst_addr", {24'd0, reg_addr}, 0);
    chk("rst_flags", {30'd0, frame_err, overrun}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Table-driven complete frames
    for (int i = 0; i < 9; i++) begin
      n0 = tx_q.size();
      w0 = wr_cyc;
      r0 = rd_cyc;
      send_frame(vecs[i].frame);
      chk($sformatf("v%0d_wr_en", i), {31'd0, reg_wr_en}, {31'd0, vecs[i].exp_wr});
      chk($sformatf("v%0d_rd_en", i), {31'd0, reg_rd_en}, {31'd0, vecs[i].exp_rd});
      if (vecs[i].exp_wr || vecs[i].exp_rd) begin
        chk($sformatf("v%0d_addr", i), {24'd0, reg_addr}, {24'd0, vecs[i].frame[23:16]});
        if (vecs[i].exp_wr)
          chk($sformatf("v%0d_wdata", i), {24'd0, reg_wdata}, {24'd0, vecs[i].frame[15:8]});
      end
      if (vecs[i].ack) begin
        do_ack(vecs[i].rdata);
        chk($sformatf("v%0d_en_drop", i), {31'd0, reg_wr_en | reg_rd_en}, 0);
        chk($sformatf("v%0d_tx_rise", i), {31'd0, tx_valid}, 1);
      end
      repeat (10) @(posedge clk);
      #1;
      chk($sformatf("v%0d_ntx", i), tx_q.size() - n0, vecs[i].ntx);
      chk($sformatf("v%0d_tx0", i), {24'd0, tx_q[n0]}, {24'd0, vecs[i].tx0});
      if (vecs[i].ntx > 1)
        chk($sformatf("v%0d_tx1", i), {24'd0, tx_q[n0+1]}, {24'd0, vecs[i].tx1});
      if (!vecs[i].exp_wr && !vecs[i].exp_rd)
        chk($sformatf("v%0d_no_bus", i), (wr_cyc - w0) + (rd_cyc - r0), 0);
      chk($sformatf("v%0d_idle_txv", i), {31'd0, tx_valid}, 0);
    end

    // Read with transmitter backpressure
    n0 = tx_q.size();
    tx_ready = 1'b0;
    send_frame(40'hA5_02_20_00_22);
    chk("bp_rd_en", {31'd0, reg_rd_en}, 1);
    do_ack(8'hC3);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", {31'd0, tx_valid}, 1);
      chk("bp_hold_data", {24'd0, tx_data}, 32'h5A);
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_b2b_valid", {31'd0, tx_valid}, 1);
    chk("bp_b2b_data", {24'd0, tx_data}, 32'hC3);
    @(posedge clk); #1;
    chk("bp_done_valid", {31'd0, tx_valid}, 0);
    chk("bp_ntx", tx_q.size() - n0, 2);

    // Inter-byte timeout: abort after TO_CYC idle cycles
    n0 = tx_q.size();
    f0 = fe_cnt;
    w0 = wr_cyc;
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TO_CYC - 1) @(posedge clk);
    #1;
    chk("to_no_early_err", {31'd0, frame_err}, 0);
    @(posedge clk); #1;
    chk("to_frame_err", {31'd0, frame_err}, 1);
    @(posedge clk); #1;
    chk("to_err_pulse", {31'd0, frame_err}, 0);
    // Rest of the old frame must now be ignored in IDLE.
    send_byte(8'h10);
    send_byte(8'h3C);
    send_byte(8'h2D);
    repeat (10) @(posedge clk);
    #1;
    chk("to_no_tx", tx_q.size() - n0, 0);
    chk("to_no_bus", wr_cyc - w0, 0);
    chk("to_err_count", fe_cnt - f0, 1);

    // Byte landing exactly on the last timeout cycle is accepted
    n0 = tx_q.size();
    f0 = fe_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TO_CYC - 2) @(posedge clk);
    send_byte(8'h10);
    send_byte(8'h3C);
    send_byte(8'h2D);
    chk("edge_wr_en", {31'd0, reg_wr_en}, 1);
    do_ack(8'h00);
    repeat (10) @(posedge clk);
    #1;
    chk("edge_no_err", fe_cnt - f0, 0);
    chk("edge_ntx", tx_q.size() - n0, 1);
    chk("edge_tx0", {24'd0, tx_q[n0]}, 32'h5A);

    // Bus timeout with an overrun byte during BUS
    n0 = tx_q.size();
    w0 = wr_cyc;
    o0 = ov_cnt;
    send_frame(40'hA5_01_10_3C_2D);
    send_byte(8'hA5);
    repeat (20) @(posedge clk);
    #1;
    chk("busto_wr_cycles", wr_cyc - w0, BUS_TO);
    chk("busto_overrun", ov_cnt - o0, 1);
    chk("busto_ntx", tx_q.size() - n0, 1);
    chk("busto_tx0", {24'd0, tx_q[n0]}, 32'hED);
    // The dropped header must not have started a frame.
    w0 = wr_cyc;
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'h3C);
    send_byte(8'h2D);
    repeat (5) @(posedge clk);
    #1;
    chk("ovr_hdr_dropped", wr_cyc - w0, 0);

    // Asynchronous reset while a read is pending on the bus
    send_frame(40'hA5_02_20_00_22);
    chk("rstbus_rd_en", {31'd0, reg_rd_en}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstbus_rd_drop", {31'd0, reg_rd_en}, 0);
    n0 = tx_q.size();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rstbus_no_tx", tx_q.size() - n0, 0);

    // Leading junk before a normal frame
    n0 = tx_q.size();
    o0 = ov_cnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(40'hA5_01_10_3C_2D);
    chk("junk_wr_en", {31'd0, reg_wr_en}, 1);
    do_ack(8'h00);
    repeat (10) @(posedge clk);
    #1;
    chk("junk_ntx", tx_q.size() - n0, 1);
    chk("junk_tx0", {24'd0, tx_q[n0]}, 32'h5A);
    chk("junk_no_overrun", ov_cnt - o0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
